// File: rtl/csa_accum_ctrl_if.sv
// Operand-in / result-out handshake bundle for the carry-save accumulator controller.
// The master drives operands and consumes results. The slave is the controller.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4
) ();
    localparam int ACC_W = WIDTH + GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Streams operands through a 3:2 carry-save stage, then ripples the redundant (S, C) pair
// down to one binary sum. in_ready and out_valid come from registered state only.
module csa_accum_ctrl #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4
) (
    input  logic            clk,
    input  logic            rst,
    csa_accum_ctrl_if.slave bus
);
    localparam int ACC_W = WIDTH + GUARD;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state;
    logic [ACC_W-1:0] s_reg;
    logic [ACC_W-1:0] c_reg;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic             valid_q;

    logic             ready;
    logic             accept;
    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] maj;
    logic [ACC_W-1:0] gen;

    assign ready  = (state == IDLE) || (state == ACCUM);
    assign accept = bus.in_valid && ready;
    assign x      = ACC_W'(bus.in_data);
    assign maj    = (s_reg & c_reg) | (s_reg & x) | (c_reg & x);
    assign gen    = s_reg & c_reg;

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_reg   <= '0;
            c_reg   <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_reg <= x;
                        c_reg <= '0;
                        ovf   <= 1'b0;
                        state <= bus.in_last ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        s_reg <= s_reg ^ c_reg ^ x;
                        c_reg <= {maj[ACC_W-2:0], 1'b0};
                        ovf   <= ovf | maj[ACC_W-1];
                        state <= bus.in_last ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
                    if (c_reg == '0) begin
                        sum_q <= s_reg;
                        ovf_q <= ovf;
                        state <= DONE;
                    end else begin
                        s_reg <= s_reg ^ c_reg;
                        c_reg <= {gen[ACC_W-2:0], 1'b0};
                        ovf   <= ovf | gen[ACC_W-1];
                    end
                end
                default: begin
                    // First DONE cycle presents the result; handshakes complete from the next.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        s_reg   <= '0;
                        c_reg   <= '0;
                        ovf     <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
